// File: rtl/jelly_stream_packet_framer.sv
// Cuts an unframed beat stream into packets of run-time unit length, flags first/last
// beats, reports last-beat alignment and pads unused tail units of the last beat.
module jelly_stream_packet_framer #(
  parameter int NUM         = 4,
  parameter int UNIT_WIDTH  = 8,
  parameter int LEN_WIDTH   = 16,
  parameter int ALIGN_WIDTH = (NUM <= 2) ? 1 : $clog2(NUM),
  parameter int DATA_WIDTH  = NUM * UNIT_WIDTH
) (
  input  logic                   reset,
  input  logic                   clk,
  input  logic                   cke,
  input  logic                   endian,
  input  logic [UNIT_WIDTH-1:0]  padding,
  input  logic [LEN_WIDTH-1:0]   param_len,
  input  logic [DATA_WIDTH-1:0]  s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   m_first,
  output logic                   m_last,
  output logic [ALIGN_WIDTH-1:0] m_align,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready
);

  // One extra bit so param_len = all-ones (2^LEN_WIDTH units) cannot overflow.
  localparam int                   CNT_WIDTH = LEN_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] NUM_C     = CNT_WIDTH'(NUM);

  logic                   start_r;
  logic [CNT_WIDTH-1:0]   remain_r;
  logic                   m_first_r;
  logic                   m_last_r;
  logic [ALIGN_WIDTH-1:0] m_align_r;
  logic [DATA_WIDTH-1:0]  m_data_r;
  logic                   m_valid_r;

  logic                   transfer_s;
  logic [CNT_WIDTH-1:0]   total_s;
  logic                   last_s;
  logic [CNT_WIDTH-1:0]   remain_next_s;
  logic [ALIGN_WIDTH-1:0] align_s;
  logic [DATA_WIDTH-1:0]  data_s;
  logic [CNT_WIDTH-1:0]   unit_idx_s;

  assign s_ready    = !m_valid_r || m_ready;
  assign transfer_s = s_valid && s_ready && cke;

  assign m_first = m_first_r;
  assign m_last  = m_last_r;
  assign m_align = m_align_r;
  assign m_data  = m_data_r;
  assign m_valid = m_valid_r;

  // Units owed for this beat, last-beat decision, alignment and padded payload.
  always_comb begin
    total_s       = {CNT_WIDTH{1'b0}};
    remain_next_s = {CNT_WIDTH{1'b0}};
    align_s       = {ALIGN_WIDTH{1'b0}};
    data_s        = s_data;
    unit_idx_s    = {CNT_WIDTH{1'b0}};

    // A start beat uses param_len directly; later beats only see the counter.
    if (start_r) begin
      total_s = {1'b0, param_len} + CNT_WIDTH'(1);
    end else begin
      total_s = remain_r;
    end

    last_s = (total_s <= NUM_C);

    if (last_s) begin
      remain_next_s = {CNT_WIDTH{1'b0}};
      align_s       = ALIGN_WIDTH'(NUM_C - total_s);
    end else begin
      remain_next_s = total_s - NUM_C;
      align_s       = {ALIGN_WIDTH{1'b0}};
    end

    for (int p = 0; p < NUM; p++) begin
      if (endian) begin
        unit_idx_s = CNT_WIDTH'(NUM - 1 - p);
      end else begin
        unit_idx_s = CNT_WIDTH'(p);
      end
      if (last_s && (unit_idx_s >= total_s)) begin
        data_s[p*UNIT_WIDTH +: UNIT_WIDTH] = padding;
      end else begin
        data_s[p*UNIT_WIDTH +: UNIT_WIDTH] = s_data[p*UNIT_WIDTH +: UNIT_WIDTH];
      end
    end
  end

  // Output register stage plus packet position state.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_r   <= 1'b1;
      remain_r  <= {CNT_WIDTH{1'b0}};
      m_first_r <= 1'b0;
      m_last_r  <= 1'b0;
      m_align_r <= {ALIGN_WIDTH{1'b0}};
      m_data_r  <= {DATA_WIDTH{1'b0}};
      m_valid_r <= 1'b0;
    end else if (cke) begin
      if (transfer_s) begin
        m_valid_r <= 1'b1;
        m_first_r <= start_r;
        m_last_r  <= last_s;
        m_align_r <= align_s;
        m_data_r  <= data_s;
        start_r   <= last_s;
        remain_r  <= remain_next_s;
      end else if (m_ready) begin
        m_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jelly_stream_packet_framer.sv
// Directed table-driven bench for jelly_stream_packet_framer (NUM=4, 8-bit units, pad 0xEE).
module tb_jelly_stream_packet_framer;

  localparam int NUM = 4;
  localparam int UW  = 8;
  localparam int LW  = 16;
  localparam int AW  = 2;
  localparam int DW  = NUM * UW;

  logic          reset;
  logic          clk;
  logic          cke;
  logic          endian;
  logic [UW-1:0] padding;
  logic [LW-1:0] param_len;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          m_first;
  logic          m_last;
  logic [AW-1:0] m_align;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;

  int checks   = 0;
  int failures = 0;

  jelly_stream_packet_framer #(
    .NUM(NUM), .UNIT_WIDTH(UW), .LEN_WIDTH(LW)
  ) dut (
    .reset(reset), .clk(clk), .cke(cke), .endian(endian), .padding(padding),
    .param_len(param_len), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_first(m_first), .m_last(m_last), .m_align(m_align), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst, ck, sv, mr, en;
    logic [LW-1:0] len;
    logic [DW-1:0] d;
    logic          sr, mv, chk, f, l;
    logic [AW-1:0] al;
    logic [DW-1:0] md;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, ck, sv, mr, en, input logic [LW-1:0] len,
                              input logic [DW-1:0] d, input logic sr, mv, chk, f, l,
                              input logic [AW-1:0] al, input logic [DW-1:0] md);
    vec_t v;
    v.rst = rst; v.ck = ck; v.sv = sv; v.mr = mr; v.en = en; v.len = len; v.d = d;
    v.sr = sr; v.mv = mv; v.chk = chk; v.f = f; v.l = l; v.al = al; v.md = md;
    return v;
  endfunction

  task automatic check(input string name, input int row, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%h expected=%h", name, row, got, exp);
    end
  endtask

  task automatic drive(input logic rst, ck, sv, mr, en, input logic [LW-1:0] len,
                       input logic [DW-1:0] d);
    @(negedge clk);
    reset = rst; cke = ck; s_valid = sv; m_ready = mr; endian = en;
    param_len = len; s_data = d;
    #1;
  endtask

  task automatic check_out(input int row, input logic mv, chk, f, l,
                           input logic [AW-1:0] al, input logic [DW-1:0] md);
    @(posedge clk);
    #1;
    check("m_valid", row, DW'(m_valid), DW'(mv));
    if (chk) begin
      check("m_first", row, DW'(m_first), DW'(f));
      check("m_last",  row, DW'(m_last),  DW'(l));
      check("m_align", row, DW'(m_align), DW'(al));
      check("m_data",  row, m_data, md);
    end
  endtask

  initial begin
    reset = 1'b1; cke = 1'b1; endian = 1'b0; padding = 8'hEE; param_len = 16'd9;
    s_data = 32'h0; s_valid = 1'b0; m_ready = 1'b1;
    repeat (2) @(posedge clk);

    // reset state
    vecs.push_back(mk(1,1,0,1,0,9,32'h0,        1,0,1,0,0,0,32'h0));
    // 10 units, endian 0
    vecs.push_back(mk(0,1,1,1,0,9,32'h03020100, 1,1,1,1,0,0,32'h03020100));
    vecs.push_back(mk(0,1,1,1,0,9,32'h07060504, 1,1,1,0,0,0,32'h07060504));
    vecs.push_back(mk(0,1,1,1,0,9,32'h0B0A0908, 1,1,1,0,1,2,32'hEEEE0908));
    vecs.push_back(mk(0,1,0,1,0,9,32'h0,        1,0,0,0,0,0,32'h0));
    // 10 units, endian 1
    vecs.push_back(mk(0,1,1,1,1,9,32'h00010203, 1,1,1,1,0,0,32'h00010203));
    vecs.push_back(mk(0,1,1,1,1,9,32'h04050607, 1,1,1,0,0,0,32'h04050607));
    vecs.push_back(mk(0,1,1,1,1,9,32'h08090A0B, 1,1,1,0,1,2,32'h0809EEEE));
    vecs.push_back(mk(0,1,0,1,1,9,32'h0,        1,0,0,0,0,0,32'h0));
    // backpressure while beat1 is presented
    vecs.push_back(mk(0,1,1,1,0,9,32'h03020100, 1,1,1,1,0,0,32'h03020100));
    vecs.push_back(mk(0,1,1,1,0,9,32'h07060504, 1,1,1,0,0,0,32'h07060504));
    vecs.push_back(mk(0,1,1,0,0,9,32'h0B0A0908, 0,1,1,0,0,0,32'h07060504));
    vecs.push_back(mk(0,1,1,0,0,9,32'h0B0A0908, 0,1,1,0,0,0,32'h07060504));
    vecs.push_back(mk(0,1,1,0,0,9,32'h0B0A0908, 0,1,1,0,0,0,32'h07060504));
    vecs.push_back(mk(0,1,1,1,0,9,32'h0B0A0908, 1,1,1,0,1,2,32'hEEEE0908));
    vecs.push_back(mk(0,1,0,1,0,9,32'h0,        1,0,0,0,0,0,32'h0));
    // param_len change mid-packet, then 2-unit packet
    vecs.push_back(mk(0,1,1,1,0,9,32'h03020100, 1,1,1,1,0,0,32'h03020100));
    vecs.push_back(mk(0,1,1,1,0,1,32'h07060504, 1,1,1,0,0,0,32'h07060504));
    vecs.push_back(mk(0,1,1,1,0,1,32'h0B0A0908, 1,1,1,0,1,2,32'hEEEE0908));
    vecs.push_back(mk(0,1,1,1,0,1,32'h33221100, 1,1,1,1,1,2,32'hEEEE1100));
    vecs.push_back(mk(0,1,0,1,0,9,32'h0,        1,0,0,0,0,0,32'h0));
    // reset mid-packet, then cke freeze mid-packet
    vecs.push_back(mk(0,1,1,1,0,9,32'h03020100, 1,1,1,1,0,0,32'h03020100));
    vecs.push_back(mk(0,1,1,1,0,9,32'h07060504, 1,1,1,0,0,0,32'h07060504));
    vecs.push_back(mk(1,1,0,1,0,9,32'h0,        1,0,1,0,0,0,32'h0));
    vecs.push_back(mk(0,1,1,1,0,9,32'h03020100, 1,1,1,1,0,0,32'h03020100));
    vecs.push_back(mk(0,0,1,1,0,9,32'h07060504, 1,1,1,1,0,0,32'h03020100));
    vecs.push_back(mk(0,0,1,1,0,9,32'h07060504, 1,1,1,1,0,0,32'h03020100));
    vecs.push_back(mk(0,1,1,1,0,9,32'h07060504, 1,1,1,0,0,0,32'h07060504));
    vecs.push_back(mk(0,1,1,1,0,9,32'h0B0A0908, 1,1,1,0,1,2,32'hEEEE0908));
    vecs.push_back(mk(0,1,0,1,0,9,32'h0,        1,0,0,0,0,0,32'h0));
    // single unit packet: three padded units
    vecs.push_back(mk(0,1,1,1,0,0,32'h44332211, 1,1,1,1,1,3,32'hEEEEEE11));
    vecs.push_back(mk(0,1,0,1,0,9,32'h0,        1,0,0,0,0,0,32'h0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ck, vecs[i].sv, vecs[i].mr, vecs[i].en, vecs[i].len, vecs[i].d);
      check("s_ready", i, DW'(s_ready), DW'(vecs[i].sr));
      check_out(i, vecs[i].mv, vecs[i].chk, vecs[i].f, vecs[i].l, vecs[i].al, vecs[i].md);
    end

    // full-throughput single-beat packets
    for (int i = 0; i < 8; i++) begin
      logic [DW-1:0] d;
      d = DW'($urandom);
      drive(0, 1, 1, 1, 0, 16'd3, d);
      check("tp_s_ready", 100 + i, DW'(s_ready), DW'(1'b1));
      check_out(100 + i, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, d);
    end
    drive(0, 1, 0, 1, 0, 16'd3, 32'h0);
    check_out(108, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);

    // maximum length: 65536 units = 16384 full beats
    for (int i = 0; i < 16384; i++) begin
      drive(0, 1, 1, 1, 0, 16'hFFFF, DW'(i));
      check_out(200, 1'b1, 1'b1, (i == 0), (i == 16383), 2'd0, DW'(i));
    end
    drive(0, 1, 0, 1, 0, 16'd9, 32'h0);
    check_out(201, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    // next packet after wrap starts fresh
    drive(0, 1, 1, 1, 0, 16'd1, 32'h5A5A1234);
    check_out(202, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 32'hEEEE1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
